uc_coordena_objetos_param: RTL and testbench
============================================

Name: uc_coordena_objetos_param

Overview:
Parametrised successor to the fixed shot/asteroid coordinator control unit. On each frame tick it walks every shot slot and then every asteroid slot, using internal index counters. For each occupied slot it issues a move request and then a collision-compare request, each with a done handshake to the datapath. Empty slots are skipped, and a per-request watchdog guarantees the frame always finishes. It sits between the game-tick generator and the object datapath (position RAMs, comparators).

Parameters:
N_TIROS, 4, number of shot slots (≥1)
N_ASTEROIDES, 8, number of asteroid slots (≥1)
IDX_W, 4, index output width; must satisfy 2^IDX_W ≥ max(N_TIROS, N_ASTEROIDES)
TIMEOUT_CICLOS, 16, cycles to wait for a done before forcing progress; 0 disables the watchdog

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
move_tiro_e_asteroides  in  1  level; start request, sampled in ESPERA
tiros_ativos  in  N_TIROS  occupancy mask, bit i = shot slot i in use
asteroides_ativos  in  N_ASTEROIDES  occupancy mask
fim_move  in  1  datapath done for current move request
fim_comparacao  in  1  datapath done for current compare request
movimenta_tiro  out  1  move request, shot[indice_tiro]
compara_tiro  out  1  compare shot[indice_tiro] vs all asteroids
movimenta_asteroide  out  1  move request, asteroid[indice_asteroide]
compara_asteroide  out  1  compare asteroid[indice_asteroide] vs ship and shots
indice_tiro  out  IDX_W  current shot slot
indice_asteroide  out  IDX_W  current asteroid slot
ocupado  out  1  high in every state except INICIAL/ESPERA
fim_move_tiro_e_asteroides  out  1  one-cycle pulse, frame complete
erro_timeout  out  1  sticky, a watchdog fired this frame
db_estado  out  5  state code

Behaviour:
- Single clock. Synchronous active-high reset, with priority over everything. It returns to INICIAL from any state, mid-frame included.
- Reset values: all outputs 0, both indices 0, watchdog 0, erro_timeout 0.
- States and db_estado codes: INICIAL 0, ESPERA 1, SEL_TIRO 2, MOVE_TIRO 3, COMP_TIRO 4, PROX_TIRO 5, SEL_AST 6, MOVE_AST 7, COMP_AST 8, PROX_AST 9, FIM 10. Unused codes go to INICIAL.
- INICIAL→ESPERA unconditionally.
- ESPERA→SEL_TIRO when move_tiro_e_asteroides=1. On this transition both indices and erro_timeout clear.
- SEL_TIRO: tiros_ativos[indice_tiro] (live) =1 → MOVE_TIRO, else → PROX_TIRO.
- MOVE_TIRO:
  - movimenta_tiro=1 (Moore) for every cycle in the state.
  - fim_move=1 → COMP_TIRO.
  - Watchdog expiry → COMP_TIRO and erro_timeout←1.
- COMP_TIRO: compara_tiro=1. fim_comparacao=1 or watchdog expiry → PROX_TIRO. Expiry sets erro_timeout.
- PROX_TIRO: if indice_tiro==N_TIROS-1, indice_tiro←0 and → SEL_AST; else indice_tiro+1 and → SEL_TIRO.
- SEL_AST, MOVE_AST, COMP_AST, PROX_AST mirror the shot states, using asteroides_ativos, fim_move, fim_comparacao and indice_asteroide. At last index → FIM.
- FIM: fim_move_tiro_e_asteroides=1 for exactly one cycle, then → ESPERA. If the start level is still high, the next frame begins on the following cycle.
- Watchdog:
  - Counter clears on entry to any MOVE/COMP state and increments each cycle while in it.
  - Expiry means count==TIMEOUT_CICLOS-1 with no done.
  - A done in the expiry cycle counts as a normal done: erro_timeout is not set.
  - TIMEOUT_CICLOS=0 means wait forever.
- Done inputs are ignored outside their states. A stale done still high on state entry is accepted immediately, so the datapath must drop done once the request deasserts.
- Latency, done returned in the same cycle as the request: inactive slot = 2 cycles, active slot = 4 cycles. Frame = 1 (ESPERA) + per-slot cycles + 1 (FIM).
- Indices hold their value outside their own phase. Output indices are never ≥ N.

Decomposition:
- Package uc_objetos_pkg holds the state encoding localparams, so the debug 7-seg decoder shares them.
- One natural sub-module: contador_indice_m (parametrised modulo-N counter with clear, enable and rco). It is instantiated twice, for shots and for asteroids.
- The watchdog counter stays inline.

Test Plan:
- Reset mid-MOVE_AST (indice_asteroide=5) → next cycle db_estado=0, all outputs 0, indices 0.
- Masks all 0, N_TIROS=4, N_ASTEROIDES=8, start high for one cycle → fim pulse exactly 26 cycles after the ESPERA cycle; no request output ever asserts.
- tiros_ativos=4'b0101, asteroides_ativos=0, done returned the same cycle → movimenta_tiro asserted only with indice_tiro=0 and 2, each for 1 cycle, with compara_tiro following.
- fim_move delayed 3 cycles at shot slot 1 → movimenta_tiro held 4 cycles, indice stable, erro_timeout stays 0.
- fim_comparacao never arrives at asteroid 7, TIMEOUT_CICLOS=16 → compara_asteroide high 16 cycles, then FIM, fim pulse, erro_timeout=1. It clears at the next start.
- Start held high continuously → back-to-back frames, one fim pulse per frame, ESPERA occupied 1 cycle between frames.

Source files
------------

// File: rtl/uc_objetos_pkg.sv
// rtl/uc_objetos_pkg.sv - state encoding shared by the coordinator and the debug display decoder
package uc_objetos_pkg;

    localparam int EST_W = 5;

    localparam logic [EST_W-1:0] EST_INICIAL   = 5'd0;
    localparam logic [EST_W-1:0] EST_ESPERA    = 5'd1;
    localparam logic [EST_W-1:0] EST_SEL_TIRO  = 5'd2;
    localparam logic [EST_W-1:0] EST_MOVE_TIRO = 5'd3;
    localparam logic [EST_W-1:0] EST_COMP_TIRO = 5'd4;
    localparam logic [EST_W-1:0] EST_PROX_TIRO = 5'd5;
    localparam logic [EST_W-1:0] EST_SEL_AST   = 5'd6;
    localparam logic [EST_W-1:0] EST_MOVE_AST  = 5'd7;
    localparam logic [EST_W-1:0] EST_COMP_AST  = 5'd8;
    localparam logic [EST_W-1:0] EST_PROX_AST  = 5'd9;
    localparam logic [EST_W-1:0] EST_FIM       = 5'd10;

    typedef enum logic [EST_W-1:0] {
        INICIAL   = EST_INICIAL,
        ESPERA    = EST_ESPERA,
        SEL_TIRO  = EST_SEL_TIRO,
        MOVE_TIRO = EST_MOVE_TIRO,
        COMP_TIRO = EST_COMP_TIRO,
        PROX_TIRO = EST_PROX_TIRO,
        SEL_AST   = EST_SEL_AST,
        MOVE_AST  = EST_MOVE_AST,
        COMP_AST  = EST_COMP_AST,
        PROX_AST  = EST_PROX_AST,
        FIM       = EST_FIM
    } estado_t;

    // States that wait on a datapath done and are therefore guarded by the watchdog
    function automatic logic estado_aguarda(input estado_t e);
        return (e == MOVE_TIRO) || (e == COMP_TIRO) || (e == MOVE_AST) || (e == COMP_AST);
    endfunction

endpackage

// File: rtl/contador_indice_m.sv
// rtl/contador_indice_m.sv - modulo-N slot index counter with clear, enable and ripple-carry out
module contador_indice_m #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] valor_o,
    output logic         rco_o
);

    localparam logic [W-1:0] ULTIMO = W'(N - 1);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (clear_i) begin
            valor_d = '0;
        end else if (enable_i) begin
            valor_d = (valor_q == ULTIMO) ? '0 : valor_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_o = valor_q;
    assign rco_o   = (valor_q == ULTIMO);

endmodule

// File: rtl/uc_coordena_objetos_param.sv
// rtl/uc_coordena_objetos_param.sv - per-frame walker issuing move/compare requests for shot and asteroid slots
module uc_coordena_objetos_param #(
    parameter int N_TIROS        = 4,
    parameter int N_ASTEROIDES   = 8,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    move_tiro_e_asteroides,
    input  logic [N_TIROS-1:0]      tiros_ativos,
    input  logic [N_ASTEROIDES-1:0] asteroides_ativos,
    input  logic                    fim_move,
    input  logic                    fim_comparacao,
    output logic                    movimenta_tiro,
    output logic                    compara_tiro,
    output logic                    movimenta_asteroide,
    output logic                    compara_asteroide,
    output logic [IDX_W-1:0]        indice_tiro,
    output logic [IDX_W-1:0]        indice_asteroide,
    output logic                    ocupado,
    output logic                    fim_move_tiro_e_asteroides,
    output logic                    erro_timeout,
    output logic [4:0]              db_estado
);

    import uc_objetos_pkg::*;

    localparam int WD_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);
    localparam logic WD_ON = (TIMEOUT_CICLOS > 0);

    estado_t         estado_q, estado_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            erro_q, erro_d;

    logic             limpa_indices;
    logic             conta_tiro;
    logic             conta_ast;
    logic             rco_tiro;
    logic             rco_ast;
    logic [IDX_W-1:0] idx_tiro;
    logic [IDX_W-1:0] idx_ast;
    logic             tiro_ativo;
    logic             ast_ativo;
    logic             wd_expira;

    contador_indice_m #(.N(N_TIROS), .W(IDX_W)) u_cont_tiro (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (limpa_indices),
        .enable_i (conta_tiro),
        .valor_o  (idx_tiro),
        .rco_o    (rco_tiro)
    );

    contador_indice_m #(.N(N_ASTEROIDES), .W(IDX_W)) u_cont_ast (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (limpa_indices),
        .enable_i (conta_ast),
        .valor_o  (idx_ast),
        .rco_o    (rco_ast)
    );

    // Live mask lookup; written as a compare loop so the index width need not match the mask size
    always_comb begin
        tiro_ativo = 1'b0;
        for (int i = 0; i < N_TIROS; i++) begin
            if (idx_tiro == IDX_W'(i)) tiro_ativo = tiros_ativos[i];
        end
        ast_ativo = 1'b0;
        for (int i = 0; i < N_ASTEROIDES; i++) begin
            if (idx_ast == IDX_W'(i)) ast_ativo = asteroides_ativos[i];
        end
    end

    assign wd_expira = WD_ON && (wd_q == WD_MAX);

    always_comb begin
        estado_d      = estado_q;
        erro_d        = erro_q;
        limpa_indices = 1'b0;
        conta_tiro    = 1'b0;
        conta_ast     = 1'b0;
        case (estado_q)
            INICIAL: estado_d = ESPERA;
            ESPERA: begin
                if (move_tiro_e_asteroides) begin
                    estado_d      = SEL_TIRO;
                    limpa_indices = 1'b1;
                    erro_d        = 1'b0;
                end
            end
            SEL_TIRO: estado_d = tiro_ativo ? MOVE_TIRO : PROX_TIRO;
            MOVE_TIRO: begin
                if (fim_move) begin
                    estado_d = COMP_TIRO;
                end else if (wd_expira) begin
                    estado_d = COMP_TIRO;
                    erro_d   = 1'b1;
                end
            end
            COMP_TIRO: begin
                if (fim_comparacao) begin
                    estado_d = PROX_TIRO;
                end else if (wd_expira) begin
                    estado_d = PROX_TIRO;
                    erro_d   = 1'b1;
                end
            end
            PROX_TIRO: begin
                conta_tiro = 1'b1;
                estado_d   = rco_tiro ? SEL_AST : SEL_TIRO;
            end
            SEL_AST: estado_d = ast_ativo ? MOVE_AST : PROX_AST;
            MOVE_AST: begin
                if (fim_move) begin
                    estado_d = COMP_AST;
                end else if (wd_expira) begin
                    estado_d = COMP_AST;
                    erro_d   = 1'b1;
                end
            end
            COMP_AST: begin
                if (fim_comparacao) begin
                    estado_d = PROX_AST;
                end else if (wd_expira) begin
                    estado_d = PROX_AST;
                    erro_d   = 1'b1;
                end
            end
            PROX_AST: begin
                conta_ast = 1'b1;
                estado_d  = rco_ast ? FIM : SEL_AST;
            end
            FIM:     estado_d = ESPERA;
            default: estado_d = INICIAL;
        endcase
    end

    // Watchdog restarts on every state change, so each MOVE/COMP entry begins at zero
    always_comb begin
        wd_d = '0;
        if ((estado_d == estado_q) && estado_aguarda(estado_q)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            wd_q     <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            wd_q     <= wd_d;
            erro_q   <= erro_d;
        end
    end

    assign movimenta_tiro             = (estado_q == MOVE_TIRO);
    assign compara_tiro               = (estado_q == COMP_TIRO);
    assign movimenta_asteroide        = (estado_q == MOVE_AST);
    assign compara_asteroide          = (estado_q == COMP_AST);
    assign indice_tiro                = idx_tiro;
    assign indice_asteroide           = idx_ast;
    assign ocupado                    = (estado_q != INICIAL) && (estado_q != ESPERA);
    assign fim_move_tiro_e_asteroides = (estado_q == FIM);
    assign erro_timeout               = erro_q;
    assign db_estado                  = estado_q;

endmodule

// File: tb/tb_uc_coordena_objetos_param.sv
// tb/tb_uc_coordena_objetos_param.sv - directed vector bench for the shot/asteroid coordinator
module tb_uc_coordena_objetos_param;

    localparam int NT = 4;
    localparam int NA = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NT-1:0] tiros;
    logic [NA-1:0] asts;
    logic          fim_move;
    logic          fim_comparacao;
    logic          movimenta_tiro, compara_tiro, movimenta_asteroide, compara_asteroide;
    logic [3:0]    indice_tiro, indice_asteroide;
    logic          ocupado, fim_frame, erro_timeout;
    logic [4:0]    db_estado;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  auto_move;
    bit  auto_comp;

    uc_coordena_objetos_param #(
        .N_TIROS(NT), .N_ASTEROIDES(NA), .IDX_W(4), .TIMEOUT_CICLOS(16)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .move_tiro_e_asteroides     (start),
        .tiros_ativos               (tiros),
        .asteroides_ativos          (asts),
        .fim_move                   (fim_move),
        .fim_comparacao             (fim_comparacao),
        .movimenta_tiro             (movimenta_tiro),
        .compara_tiro               (compara_tiro),
        .movimenta_asteroide        (movimenta_asteroide),
        .compara_asteroide          (compara_asteroide),
        .indice_tiro                (indice_tiro),
        .indice_asteroide           (indice_asteroide),
        .ocupado                    (ocupado),
        .fim_move_tiro_e_asteroides (fim_frame),
        .erro_timeout               (erro_timeout),
        .db_estado                  (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NT-1:0] t;
        logic [NA-1:0] a;
        int            len;
    } vetor_t;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge; auto mode answers requests in the same cycle
    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_move) fim_move = movimenta_tiro | movimenta_asteroide;
        if (auto_comp) fim_comparacao = compara_tiro | compara_asteroide;
    endtask

    task automatic wait_espera();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (db_estado == 5'd1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_espera", 32'(ok), 32'd1);
    endtask

    task automatic run_frame(input vetor_t v, input int k);
        int            len = 1;
        int            nmt = 0, nma = 0, nct = 0, nca = 0, bad = 0;
        logic [NT-1:0] mt_mask = '0;
        logic [NA-1:0] ma_mask = '0;
        bit            done = 1'b0;
        wait_espera();
        tiros = v.t;
        asts  = v.a;
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            start = 1'b0;
            len++;
            if (indice_tiro >= NT || indice_asteroide >= NA) bad++;
            if (ocupado !== (db_estado > 5'd1)) bad++;
            if (movimenta_tiro) begin nmt++; mt_mask[indice_tiro[1:0]] = 1'b1; end
            if (movimenta_asteroide) begin nma++; ma_mask[indice_asteroide[2:0]] = 1'b1; end
            if (compara_tiro) nct++;
            if (compara_asteroide) nca++;
            if (fim_frame) begin done = 1'b1; break; end
        end
        check($sformatf("v%0d_done", k), 32'(done), 32'd1);
        check($sformatf("v%0d_len", k), 32'(len), 32'(v.len));
        check($sformatf("v%0d_tiro_mask", k), 32'(mt_mask), 32'(v.t));
        check($sformatf("v%0d_ast_mask", k), 32'(ma_mask), 32'(v.a));
        check($sformatf("v%0d_n_mov_tiro", k), 32'(nmt), 32'($countones(v.t)));
        check($sformatf("v%0d_n_mov_ast", k), 32'(nma), 32'($countones(v.a)));
        check($sformatf("v%0d_n_comp_tiro", k), 32'(nct), 32'($countones(v.t)));
        check($sformatf("v%0d_n_comp_ast", k), 32'(nca), 32'($countones(v.a)));
        check($sformatf("v%0d_bad", k), 32'(bad), 32'd0);
        check($sformatf("v%0d_erro", k), 32'(erro_timeout), 32'd0);
        tick();
        check($sformatf("v%0d_fim_1cyc", k), 32'(fim_frame), 32'd0);
        check($sformatf("v%0d_espera", k), 32'(db_estado), 32'd1);
    endtask

    vetor_t vetores[5];

    initial begin
        int cnt, idx_bad, fims, esp, occ_low, ultimo;
        bit ok;

        // Frame length = 1 + 2*inactive + 4*active + 1 over 12 slots
        vetores[0] = '{t: 4'b0000, a: 8'h00, len: 26};
        vetores[1] = '{t: 4'b0101, a: 8'h00, len: 30};
        vetores[2] = '{t: 4'b1111, a: 8'hFF, len: 50};
        vetores[3] = '{t: 4'b1000, a: 8'h81, len: 32};
        vetores[4] = '{t: 4'b0000, a: 8'hA5, len: 34};

        reset = 1'b1; start = 1'b0; tiros = '0; asts = '0;
        fim_move = 1'b0; fim_comparacao = 1'b0;
        auto_move = 1'b1; auto_comp = 1'b1;
        tick(); tick();
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_reqs", 32'({movimenta_tiro, compara_tiro, movimenta_asteroide, compara_asteroide}), 32'd0);
        check("rst_idx", 32'({indice_tiro, indice_asteroide}), 32'd0);
        check("rst_fim_erro", 32'({fim_frame, erro_timeout}), 32'd0);
        reset = 1'b0;
        tick();
        check("inicial_to_espera", 32'(db_estado), 32'd1);

        for (int k = 0; k < 5; k++) run_frame(vetores[k], k);

        // fim_move withheld for three cycles at shot slot 1
        wait_espera();
        auto_move = 1'b0; fim_move = 1'b0;
        tiros = 4'b0010; asts = 8'h00; start = 1'b1;
        cnt = 0; idx_bad = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (movimenta_tiro) begin
                cnt++;
                if (indice_tiro != 4'd1) idx_bad++;
                fim_move = (cnt >= 4);
            end else begin
                fim_move = 1'b0;
            end
            if (fim_frame) begin ok = 1'b1; break; end
        end
        check("delay_done", 32'(ok), 32'd1);
        check("delay_mov_cycles", 32'(cnt), 32'd4);
        check("delay_idx", 32'(idx_bad), 32'd0);
        check("delay_erro", 32'(erro_timeout), 32'd0);
        auto_move = 1'b1;

        // fim_comparacao never returned at asteroid 7
        wait_espera();
        auto_comp = 1'b0; fim_comparacao = 1'b0;
        tiros = 4'b0000; asts = 8'h80; start = 1'b1;
        cnt = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (compara_asteroide) begin
                cnt++;
                if (indice_asteroide != 4'd7) idx_bad++;
            end
            if (fim_frame) begin ok = 1'b1; break; end
        end
        check("to_done", 32'(ok), 32'd1);
        check("to_comp_cycles", 32'(cnt), 32'd16);
        check("to_erro", 32'(erro_timeout), 32'd1);
        check("to_idx", 32'(idx_bad), 32'd0);
        tick();
        check("to_erro_sticky", 32'(erro_timeout), 32'd1);
        wait_espera();
        asts = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        check("to_erro_clear", 32'(erro_timeout), 32'd0);
        check("to_sel_tiro", 32'(db_estado), 32'd2);

        // done arriving in the expiry cycle is a normal done
        wait_espera();
        asts = 8'h80; start = 1'b1; cnt = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (compara_asteroide) begin
                cnt++;
                fim_comparacao = (cnt == 16);
            end else begin
                fim_comparacao = 1'b0;
            end
            if (fim_frame) begin ok = 1'b1; break; end
        end
        check("exp_done", 32'(ok), 32'd1);
        check("exp_comp_cycles", 32'(cnt), 32'd16);
        check("exp_erro", 32'(erro_timeout), 32'd0);
        fim_comparacao = 1'b0; auto_comp = 1'b1;

        // Reset in MOVE_AST at asteroid 5
        wait_espera();
        tiros = 4'b0000; asts = 8'hFF; start = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (movimenta_asteroide && indice_asteroide == 4'd5) begin ok = 1'b1; break; end
        end
        check("mid_reached", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_estado", 32'(db_estado), 32'd0);
        check("mid_reqs", 32'({movimenta_tiro, compara_tiro, movimenta_asteroide, compara_asteroide, ocupado, fim_frame}), 32'd0);
        check("mid_idx", 32'({indice_tiro, indice_asteroide}), 32'd0);

        // Start held high: back-to-back 26-cycle frames
        asts = 8'h00;
        wait_espera();
        start = 1'b1;
        fims = 0; esp = 0; occ_low = 0; ultimo = 0;
        for (int i = 1; i <= 77; i++) begin
            tick();
            if (fim_frame) begin fims++; ultimo = i; end
            if (db_estado == 5'd1) esp++;
            if (!ocupado) occ_low++;
        end
        start = 1'b0;
        check("b2b_fims", 32'(fims), 32'd3);
        check("b2b_espera", 32'(esp), 32'd2);
        check("b2b_ocup_low", 32'(occ_low), 32'd2);
        check("b2b_last_fim", 32'(ultimo), 32'd77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
